// File: rtl/regfile_sb.sv
// Parametrised integer register file with a pending-write scoreboard.
// Optional same-cycle writeback forwarding to read data and busy outputs.
module regfile_sb #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int AW       = $clog2(NREG),
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  output logic            busy1,
  output logic            busy2,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic            issue,
  input  logic [AW-1:0]   issue_rd,
  input  logic            flush,
  output logic            any_busy
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [NREG-1:0] pend_q;
  logic [NREG-1:0] pend_d;

  logic wr_ok;
  logic byp_en;
  logic hit1;
  logic hit2;
  logic zr1;
  logic zr2;

  function automatic logic writable(input logic [AW-1:0] a);
    return (ZERO_REG == 0) || (a != '0);
  endfunction

  assign wr_ok  = we && writable(waddr);
  // forwarding is suppressed while reset is held so outputs read as zero
  assign byp_en = (BYPASS != 0) && rst_n && wr_ok;
  assign hit1   = byp_en && (waddr == rs1);
  assign hit2   = byp_en && (waddr == rs2);
  assign zr1    = (ZERO_REG != 0) && (rs1 == '0);
  assign zr2    = (ZERO_REG != 0) && (rs2 == '0);

  always_comb begin
    rdata1 = regs_q[rs1];
    if (hit1) rdata1 = wdata;
    if (zr1)  rdata1 = '0;
  end

  always_comb begin
    rdata2 = regs_q[rs2];
    if (hit2) rdata2 = wdata;
    if (zr2)  rdata2 = '0;
  end

  assign busy1    = pend_q[rs1] && !hit1 && !zr1;
  assign busy2    = pend_q[rs2] && !hit2 && !zr2;
  assign any_busy = |pend_q;

  always_comb begin
    pend_d = pend_q;
    for (int i = 0; i < NREG; i++) begin
      if (flush)
        pend_d[i] = 1'b0;
      else if (issue && issue_rd == AW'(i) && writable(AW'(i)))
        pend_d[i] = 1'b1;
      else if (we && waddr == AW'(i))
        pend_d[i] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      for (int i = 0; i < NREG; i++)
        regs_q[i] <= '0;
    end else begin
      pend_q <= pend_d;
      if (wr_ok)
        regs_q[waddr] <= wdata;
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: default instance plus a
// 64-bit / 16-entry instance without zero register or bypass.
module tb_regfile_sb;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [4:0]  a_rs1, a_rs2, a_waddr, a_ird;
  logic [31:0] a_rd1, a_rd2, a_wdata;
  logic        a_b1, a_b2, a_we, a_iss, a_fl, a_any;

  logic [3:0]  b_rs1, b_rs2, b_waddr, b_ird;
  logic [63:0] b_rd1, b_rd2, b_wdata;
  logic        b_b1, b_b2, b_we, b_iss, b_fl, b_any;

  regfile_sb u_a (
    .clk(clk), .rst_n(rst_n),
    .rs1(a_rs1), .rs2(a_rs2),
    .rdata1(a_rd1), .rdata2(a_rd2),
    .busy1(a_b1), .busy2(a_b2),
    .we(a_we), .waddr(a_waddr), .wdata(a_wdata),
    .issue(a_iss), .issue_rd(a_ird),
    .flush(a_fl), .any_busy(a_any)
  );

  regfile_sb #(
    .XLEN(64), .NREG(16), .ZERO_REG(0), .BYPASS(0)
  ) u_b (
    .clk(clk), .rst_n(rst_n),
    .rs1(b_rs1), .rs2(b_rs2),
    .rdata1(b_rd1), .rdata2(b_rd2),
    .busy1(b_b1), .busy2(b_b2),
    .we(b_we), .waddr(b_waddr), .wdata(b_wdata),
    .issue(b_iss), .issue_rd(b_ird),
    .flush(b_fl), .any_busy(b_any)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_we = 0; a_iss = 0; a_fl = 0;
    b_we = 0; b_iss = 0; b_fl = 0;
  endtask

  logic [63:0] m_regs [16];
  logic [15:0] m_pend;
  logic [63:0] n_regs [16];
  logic [15:0] n_pend;

  initial begin
    rst_n = 0;
    a_rs1 = 0; a_rs2 = 0; a_waddr = 0; a_ird = 0; a_wdata = 0;
    b_rs1 = 0; b_rs2 = 0; b_waddr = 0; b_ird = 0; b_wdata = 0;
    idle();
    #3;
    chk("rst_rd1", a_rd1, 0);
    chk("rst_any", a_any, 0);
    #9 rst_n = 1;
    tick();

    // r5 <- DEADBEEF, issue r5, then async reset mid-cycle
    a_we = 1; a_waddr = 5; a_wdata = 32'hDEADBEEF;
    a_iss = 1; a_ird = 5;
    tick();
    idle();
    a_rs1 = 5;
    #1;
    chk("pre_rd1", a_rd1, 32'hDEADBEEF);
    chk("pre_b1", a_b1, 1);
    chk("pre_any", a_any, 1);
    rst_n = 0;
    #1;
    chk("mid_rst_rd1", a_rd1, 0);
    chk("mid_rst_b1", a_b1, 0);
    chk("mid_rst_any", a_any, 0);
    #1 rst_n = 1;
    tick();

    // zero register
    a_we = 1; a_waddr = 0; a_wdata = 32'h12345678;
    a_iss = 1; a_ird = 0; a_rs1 = 0;
    b_we = 1; b_waddr = 0; b_wdata = 64'h12345678;
    b_iss = 1; b_ird = 0; b_rs1 = 0;
    #1;
    chk("z_same_rd1", a_rd1, 0);
    chk("nz_same_rd1", b_rd1, 0);
    tick();
    idle();
    #1;
    chk("z_rd1", a_rd1, 0);
    chk("z_b1", a_b1, 0);
    chk("z_any", a_any, 0);
    chk("nz_rd1", b_rd1, 64'h12345678);
    chk("nz_b1", b_b1, 1);

    // bypass setup: pend r7; on B clear r0 too
    a_iss = 1; a_ird = 7;
    b_iss = 1; b_ird = 7;
    b_we = 1; b_waddr = 0; b_wdata = 0;
    tick();
    idle();
    a_rs1 = 7; b_rs1 = 7;
    #1;
    chk("byp_pre_b1", a_b1, 1);
    chk("nb_pre_any", b_any, 1);
    a_we = 1; a_waddr = 7; a_wdata = 32'hA5A5A5A5;
    b_we = 1; b_waddr = 7; b_wdata = 64'hA5A5A5A5;
    #1;
    chk("byp_rd1", a_rd1, 32'hA5A5A5A5);
    chk("byp_b1", a_b1, 0);
    chk("nb_rd1_old", b_rd1, 0);
    chk("nb_b1_old", b_b1, 1);
    tick();
    idle();
    #1;
    chk("byp_rd1_next", a_rd1, 32'hA5A5A5A5);
    chk("byp_b1_next", a_b1, 0);
    chk("nb_rd1_next", b_rd1, 64'hA5A5A5A5);
    chk("nb_b1_next", b_b1, 0);
    chk("nb_any_next", b_any, 0);

    // set beats clear on r3
    a_iss = 1; a_ird = 3;
    tick();
    a_iss = 1; a_ird = 3;
    a_we = 1; a_waddr = 3; a_wdata = 32'h55;
    tick();
    idle();
    a_rs1 = 3; a_rs2 = 3;
    #1;
    chk("sbc_rd1", a_rd1, 32'h55);
    chk("sbc_b1", a_b1, 1);
    chk("sbc_b2", a_b2, 1);

    // flush priority
    a_iss = 1; a_ird = 1;
    tick();
    a_iss = 1; a_ird = 9;
    tick();
    idle();
    a_rs1 = 9;
    #1;
    chk("fl_pre_b1", a_b1, 1);
    a_fl = 1;
    a_iss = 1; a_ird = 4;
    a_we = 1; a_waddr = 2; a_wdata = 32'h77;
    tick();
    idle();
    a_rs1 = 2; a_rs2 = 4;
    #1;
    chk("fl_any", a_any, 0);
    chk("fl_rd1", a_rd1, 32'h77);
    chk("fl_b2", a_b2, 0);
    a_rs2 = 3;
    #1;
    chk("fl_keep_r3", a_rd2, 32'h55);

    // parameter sweep on B from a clean reset
    rst_n = 0;
    #2 rst_n = 1;
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    m_pend = '0;
    tick();
    b_we = 1; b_waddr = 15; b_wdata = '1;
    tick();
    idle();
    m_regs[15] = '1;
    b_rs1 = 15;
    #1;
    chk("top_rd1", b_rd1, 64'hFFFF_FFFF_FFFF_FFFF);

    for (int c = 0; c < 200; c++) begin
      b_we    = $urandom_range(0, 1) == 1;
      b_waddr = 4'($urandom);
      b_wdata = {$urandom, $urandom};
      b_iss   = $urandom_range(0, 2) != 0;
      b_ird   = 4'($urandom);
      b_fl    = $urandom_range(0, 15) == 0;
      b_rs1   = 4'($urandom);
      b_rs2   = 4'($urandom);
      #1;
      chk("rnd_rd1", b_rd1, m_regs[b_rs1]);
      chk("rnd_rd2", b_rd2, m_regs[b_rs2]);
      chk("rnd_b1", b_b1, m_pend[b_rs1]);
      chk("rnd_b2", b_b2, m_pend[b_rs2]);
      chk("rnd_any", b_any, m_pend != 0);
      n_regs = m_regs;
      n_pend = m_pend;
      if (b_we) begin
        n_regs[b_waddr] = b_wdata;
        n_pend[b_waddr] = 1'b0;
      end
      if (b_iss) n_pend[b_ird] = 1'b1;
      if (b_fl) n_pend = '0;
      tick();
      m_regs = n_regs;
      m_pend = n_pend;
    end
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised integer register file with a per-register pending-write scoreboard and optional write-to-read bypass. Next-generation replacement for the core's fixed 32×32 register file. It sits between decode/issue, which reads operands and marks destinations pending, and writeback, which writes results and clears pending bits. Issue logic uses the busy outputs to stall on RAW hazards.

## Interface
Parameters:
- XLEN, 32: data width in bits.
- NREG, 32: number of architectural registers; must be a power of two and at least 2.
- AW, $clog2(NREG): register-address width; derived, never overridden.
- ZERO_REG, 1: when 1, register 0 is hardwired to zero and never pending.
- BYPASS, 1: when 1, a same-cycle writeback is forwarded to the read ports and to the busy outputs.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- rs1  in  AW  read address, port 1.
- rs2  in  AW  read address, port 2.
- rdata1  out  XLEN  read data, port 1 (combinational).
- rdata2  out  XLEN  read data, port 2 (combinational).
- busy1  out  1  rs1 has a pending write (combinational).
- busy2  out  1  rs2 has a pending write (combinational).
- we  in  1  writeback enable.
- waddr  in  AW  writeback register.
- wdata  in  XLEN  writeback data.
- issue  in  1  mark issue_rd pending.
- issue_rd  in  AW  destination of the issuing instruction.
- flush  in  1  synchronous clear of all pending bits.
- any_busy  out  1  OR of all pending bits (registered state, combinational OR).

## Operation
- State:
  - regs[0..NREG-1], XLEN bits each.
  - pend[NREG-1:0].
- Writable register: ZERO_REG=0, or address ≠ 0.
- Write:
  - On the clock edge with we=1 and waddr writable: regs[waddr] <= wdata.
  - Writes to register 0 are dropped when ZERO_REG=1.
- Read, port n:
  - If ZERO_REG=1 and rsn=0: returns 0.
  - Else if BYPASS=1, we=1, waddr=rsn and waddr writable: returns wdata.
  - Else: returns regs[rsn].
- Scoreboard next-state, per bit i, in priority order:
  1. flush=1 → 0.
  2. issue=1, issue_rd=i and i writable → 1. Set beats clear: the newer producer wins over an older writeback to the same register in the same cycle.
  3. we=1, waddr=i → 0.
  4. Otherwise hold.
- WAW handling:
  - Issuing to an already-pending register keeps pend=1.
  - The first subsequent writeback clears it.
  - Issue logic must not issue WAW to an in-flight destination; this block does not check for it.
- Busy outputs:
  - busyn = pend[rsn] & ~(BYPASS & we & waddr==rsn).
  - With ZERO_REG=1 and rsn=0, busyn=0.
- flush does not touch regs. Writebacks in the flush cycle still update regs.
- Reset, asynchronous on rst_n low:
  - All regs are cleared to 0 and all pend bits to 0.
  - While reset is held: rdata1/2 show 0, busy1/2=0, any_busy=0.
  - Reset asserted mid-operation discards all pending state immediately.

## Timing
- Read latency: 0 cycles (combinational from rs1/rs2, regs, pend, and the write inputs).
- Write latency:
  - Array value visible on the cycle after the edge.
  - With BYPASS=1, the value is also visible in the write cycle.
  - With BYPASS=0, a same-cycle read returns the old value and busy stays 1 until the edge.
- Issue marking: pend is set at the edge, so busy is visible to reads from the next cycle.
- No handshake: every input is sampled at each rising edge. There are no backpressure outputs other than the busy signals.
- All outputs are stable after rst_n deasserts; the first state update is at the first rising edge with rst_n=1.

## Test plan
- **Reset:** preload r5=0xDEADBEEF with pend[5]=1, then pulse rst_n low mid-cycle → rdata for rs1=5 is 0, busy1=0 and any_busy=0 without waiting for a clock edge.
- **Zero register:** write r0=0x12345678 and issue issue_rd=0 → rdata1(rs1=0)=0, busy1=0, any_busy=0. With ZERO_REG=0 the same sequence reads back 0x12345678.
- **Bypass:** BYPASS=1, we=1, waddr=rs1=7, wdata=0xA5A5A5A5 with pend[7]=1 → same cycle rdata1=0xA5A5A5A5 and busy1=0. With BYPASS=0 → same cycle rdata1 is the old value and busy1=1; next cycle rdata1=0xA5A5A5A5 and busy1=0.
- **Set-beats-clear:** with pend[3]=1, in the same cycle set issue=1, issue_rd=3, we=1, waddr=3, wdata=0x55 → after the edge regs[3]=0x55 and pend[3]=1 (busy for rs=3 stays 1).
- **Flush priority:** with pend[1]=pend[9]=1, in the same cycle set flush=1, issue=1, issue_rd=4, we=1, waddr=2, wdata=0x77 → after the edge any_busy=0 and regs[2]=0x77.
- **Parameter sweep:** XLEN=64, NREG=16 → random issue/write/read traffic matches a reference model, including a write to r15 (top index) and a read back of 0xFFFF_FFFF_FFFF_FFFF.
